// File: rtl/float_packer_if.sv
// rtl/float_packer_if.sv - input/output handshake bundle for the Q1.31 to IEEE-754 packer
interface float_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    // Block side: consumes the fixed-point operand, produces the float
    modport slave (
        input  in_valid,
        input  in_sign,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    // Producer/consumer side facing the block
    modport master (
        output in_valid,
        output in_sign,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/float_packer.sv
// rtl/float_packer.sv - signed-magnitude Q1.31 to IEEE-754 single precision converter
module float_packer #(
    parameter bit FAST_SHIFT    = 1'b1,
    parameter bit ROUND_NEAREST = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    float_packer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] work;
    logic [31:0] work_n;
    logic [5:0]  lz;
    logic [5:0]  lz_n;
    logic        sign_r;
    logic        sign_n;
    logic [31:0] out_data_r;
    logic [31:0] out_data_n;

    logic [7:0]  exp_raw;
    logic        round_up;
    logic [30:0] body;

    // Pack the normalised word: lz never exceeds 31, so 8 bits of exponent
    // cannot wrap; a mantissa carry ripples into the exponent naturally.
    always_comb begin
        exp_raw  = 8'd127 - {2'b00, lz};
        round_up = ROUND_NEAREST && work[7] && ((|work[6:0]) || work[8]);
        body     = {exp_raw, work[30:8]} + {30'd0, round_up};
    end

    // Next-state and datapath update: load in IDLE, shift/pack in NORM, hold in DONE
    always_comb begin
        state_n    = state;
        work_n     = work;
        lz_n       = lz;
        sign_n     = sign_r;
        out_data_n = out_data_r;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    work_n  = bus.in_data;
                    sign_n  = bus.in_sign;
                    lz_n    = 6'd0;
                    state_n = NORM;
                end
            end
            NORM: begin
                if (work == 32'd0) begin
                    out_data_n = 32'h0000_0000;
                    state_n    = DONE;
                end else if (work[31]) begin
                    out_data_n = {sign_r, body};
                    state_n    = DONE;
                end else if (FAST_SHIFT && (work[31:28] == 4'h0)) begin
                    work_n = work << 4;
                    lz_n   = lz + 6'd4;
                end else begin
                    work_n = work << 1;
                    lz_n   = lz + 6'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            work       <= 32'd0;
            lz         <= 6'd0;
            sign_r     <= 1'b0;
            out_data_r <= 32'd0;
        end else begin
            state      <= state_n;
            work       <= work_n;
            lz         <= lz_n;
            sign_r     <= sign_n;
            out_data_r <= out_data_n;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_data_r;
endmodule

// File: tb/tb_float_packer.sv
// tb/tb_float_packer.sv - self-checking bench for float_packer in two parameter configurations
module tb_float_packer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    float_packer_if ia ();
    float_packer_if ib ();

    // a: fast shift, truncate; b: single-bit shift, round-to-nearest-even
    float_packer #(.FAST_SHIFT(1'b1), .ROUND_NEAREST(1'b0)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    float_packer #(.FAST_SHIFT(1'b0), .ROUND_NEAREST(1'b1)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int lead_zeros(input logic [31:0] x);
        int n;
        n = 0;
        while (n < 32 && x[31-n] == 1'b0) n++;
        return n;
    endfunction

    // Value-level reference: normalise, take 23 fraction bits, round on the dropped byte
    function automatic logic [31:0] ref_pack(input logic s, input logic [31:0] x, input bit rne);
        int          lz;
        logic [31:0] n;
        logic [30:0] mag;
        logic [7:0]  dropped;
        if (x == 32'd0) return 32'd0;
        lz      = lead_zeros(x);
        n       = x << lz;
        mag     = {8'(127 - lz), n[30:8]};
        dropped = n[7:0];
        if (rne && (dropped > 8'h80 || (dropped == 8'h80 && n[8]))) mag = mag + 31'd1;
        return {s, mag};
    endfunction

    function automatic int ref_lat(input logic [31:0] x, input bit fast);
        int lz;
        if (x == 32'd0) return 1;
        lz = lead_zeros(x);
        return fast ? (1 + lz / 4 + lz % 4) : (1 + lz);
    endfunction

    function automatic logic [31:0] unpack(input logic [31:0] f);
        logic [31:0] m;
        int          sh;
        m  = {1'b1, f[22:0], 8'h00};
        sh = 127 - int'(f[30:23]);
        return m >> sh;
    endfunction

    function automatic logic [31:0] top24(input logic [31:0] x);
        int p;
        p = 31 - lead_zeros(x);
        if (p >= 23) return x & ~((32'h1 << (p - 23)) - 32'h1);
        return x;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        ia.in_valid = v; ia.in_sign = s; ia.in_data = d;
        ib.in_valid = v; ib.in_sign = s; ib.in_data = d;
    endtask

    task automatic txn(input logic s, input logic [31:0] d, input int hold);
        logic [31:0] ea, eb;
        int          la, lb;
        bit          overlap;
        ea = ref_pack(s, d, 1'b0);
        eb = ref_pack(s, d, 1'b1);
        @(negedge clk);
        drive(1'b1, s, d);
        check("in_ready_a_idle", 32'(ia.in_ready), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'($urandom), $urandom);
        la = -1; lb = -1; overlap = 1'b0;
        for (int c = 1; c <= 40 && (la < 0 || lb < 0); c++) begin
            @(negedge clk);
            if (ia.out_valid && la < 0) la = c;
            if (ib.out_valid && lb < 0) lb = c;
            if ((ia.in_ready && ia.out_valid) || (ib.in_ready && ib.out_valid)) overlap = 1'b1;
        end
        check("latency_a", 32'(la), 32'(ref_lat(d, 1'b1)));
        check("latency_b", 32'(lb), 32'(ref_lat(d, 1'b0)));
        check("data_a", ia.out_data, ea);
        check("data_b", ib.out_data, eb);
        check("no_overlap", 32'(overlap), 32'd0);
        if (d != 32'd0) check("roundtrip_a", unpack(ia.out_data), top24(d));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_data_a", ia.out_data, ea);
            check("hold_data_b", ib.out_data, eb);
            check("hold_in_ready", 32'({ia.in_ready, ib.in_ready}), 32'd0);
            check("hold_out_valid", 32'({ia.out_valid, ib.out_valid}), 32'd3);
        end
        ia.out_ready = 1'b1;
        ib.out_ready = 1'b1;
        @(negedge clk);
        ia.out_ready = 1'b0;
        ib.out_ready = 1'b0;
        check("release_idle", 32'({ia.in_ready, ia.out_valid, ib.in_ready, ib.out_valid}), 32'b1010);
    endtask

    initial begin
        logic [31:0] x;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b0, 1'b0, 32'd0);
        ia.out_ready = 1'b0;
        ib.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_a", {ia.in_ready, ia.out_valid, ia.out_data[29:0]}, {1'b1, 31'd0});
        check("reset_b", {ib.in_ready, ib.out_valid, ib.out_data[29:0]}, {1'b1, 31'd0});
        check("reset_data_hi", 32'({ia.out_data[31:30], ib.out_data[31:30]}), 32'd0);
        rst = 1'b0;

        txn(1'b0, 32'h8000_0000, 0);
        check("one_point_zero", ia.out_data, 32'h3F80_0000);
        txn(1'b1, 32'h4000_0000, 0);
        check("minus_half", ia.out_data, 32'hBF00_0000);
        txn(1'b0, 32'h0000_0001, 2);
        check("smallest", ia.out_data, 32'h3000_0000);
        txn(1'b1, 32'h0000_0000, 0);
        check("neg_zero", ia.out_data, 32'h0000_0000);
        txn(1'b0, 32'hFFFF_FFFF, 5);
        check("all_ones_trunc", ia.out_data, 32'h3FFF_FFFF);
        check("all_ones_rne", ib.out_data, 32'h4000_0000);
        txn(1'b0, 32'h8000_0180, 0);
        check("tie_odd_rne", ib.out_data, 32'h3F80_0002);

        // Asynchronous reset in the middle of a long normalisation
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h0000_0001);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midnorm_reset_a", {ia.in_ready, ia.out_valid, ia.out_data[29:0]}, {1'b1, 31'd0});
        check("midnorm_reset_b", {ib.in_ready, ib.out_valid, ib.out_data[29:0]}, {1'b1, 31'd0});
        @(negedge clk);
        rst = 1'b0;
        txn(1'b1, 32'h0123_4567, 0);

        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            x = x >> $urandom_range(0, 31);
            if (i % 8 == 3) x = x | 32'h0000_0080;
            txn(1'($urandom), x, (i % 10 == 0) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
